// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver that assembles little-endian bytes into words and
// queues them in a first-word-fall-through FIFO with valid/ready output.
module uart_word_receiver #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned BYTE_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned CLK_FREQ   = 200_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sig_in,
    output logic [WORD_WIDTH-1:0]         word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_error,
    output logic                          overflow
);

    localparam int unsigned CLKS_PER_BIT   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF           = CLKS_PER_BIT / 2;
    localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / BYTE_WIDTH;
    localparam int unsigned TMR_W          = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W          = $clog2(BYTE_WIDTH + 1);
    localparam int unsigned BIDX_W         = $clog2(BYTES_PER_WORD + 1);
    localparam int unsigned PTR_W          = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W          = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    logic                  r_sync1;
    logic                  r_sync2;
    rx_state_t             r_state;
    logic                  r_armed;
    logic [TMR_W-1:0]      r_timer;
    logic [BIT_W-1:0]      r_bit_idx;
    logic [BYTE_WIDTH-1:0] r_shift;
    logic [BIDX_W-1:0]     r_byte_idx;
    logic [WORD_WIDTH-1:0] r_word;
    logic                  r_push_pending;
    logic                  r_frame_error;

    logic [WORD_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;
    logic [WORD_WIDTH-1:0] r_word_out;
    logic                  r_overflow;

    logic                  w_rx_s;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_count_after_pop;
    logic [CNT_W-1:0]      w_count_next;
    logic [PTR_W-1:0]      w_rd_next;

    assign w_rx_s            = r_sync2;
    assign w_full            = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push            = r_push_pending && !w_full;
    assign w_pop             = r_valid && word_ready;
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_count_next      = w_count_after_pop + CNT_W'(w_push);
    assign w_rd_next         = r_rd_ptr + PTR_W'(w_pop);

    assign word_out    = r_word_out;
    assign word_valid  = r_valid;
    assign fifo_count  = r_count;
    assign frame_error = r_frame_error;
    assign overflow    = r_overflow;

    // Two-flop synchroniser, idle-high reset value
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM and word assembly
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_armed        <= 1'b1;
            r_timer        <= '0;
            r_bit_idx      <= '0;
            r_shift        <= '0;
            r_byte_idx     <= '0;
            r_word         <= '0;
            r_push_pending <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_push_pending <= 1'b0;
            r_frame_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // After a framing error the line must return high before a new start
                    if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= S_START;
                        r_timer <= '0;
                    end
                end
                S_START: begin
                    if (r_timer == TMR_W'(HALF - 1)) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_timer == TMR_W'(CLKS_PER_BIT - 1)) begin
                        r_timer <= '0;
                        r_shift <= {w_rx_s, r_shift[BYTE_WIDTH-1:1]};
                        if (r_bit_idx == BIT_W'(BYTE_WIDTH - 1)) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_W'(1);
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_timer == TMR_W'(CLKS_PER_BIT - 1)) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        if (w_rx_s) begin
                            for (int k = 0; k < BYTES_PER_WORD; k++) begin
                                if (r_byte_idx == BIDX_W'(k)) begin
                                    r_word[k*BYTE_WIDTH +: BYTE_WIDTH] <= r_shift;
                                end
                            end
                            if (r_byte_idx == BIDX_W'(BYTES_PER_WORD - 1)) begin
                                r_byte_idx     <= '0;
                                r_push_pending <= 1'b1;
                            end else begin
                                r_byte_idx <= r_byte_idx + BIDX_W'(1);
                            end
                        end else begin
                            r_frame_error <= 1'b1;
                            r_byte_idx    <= '0;
                            r_armed       <= 1'b0;
                        end
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage; contents are invalidated by pointer reset
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_word;
        end
    end

    // FIFO pointers, occupancy and fall-through head register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_word_out <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != '0);
            if (r_push_pending && w_full) begin
                r_overflow <= 1'b1;
            end
            if (w_push && (w_count_after_pop == '0)) begin
                r_word_out <= r_word;
            end else if (w_pop && (w_count_after_pop != '0)) begin
                r_word_out <= r_mem[w_rd_next];
            end
        end
    end

endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver at 16 clocks/bit with a 4-entry FIFO.
module tb_uart_word_receiver;

    logic        clock;
    logic        reset;
    logic        sig_in;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic [2:0]  fifo_count;
    logic        frame_error;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt   = 0;

    uart_word_receiver #(
        .WORD_WIDTH (32),
        .BYTE_WIDTH (8),
        .FIFO_DEPTH (4),
        .CLK_FREQ   (1600),
        .BAUD_RATE  (100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig_in      (sig_in),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .fifo_count  (fifo_count),
        .frame_error (frame_error),
        .overflow    (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (frame_error) fe_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic send_bit(input logic v);
        sig_in = v;
        repeat (16) @(negedge clock);
    endtask

    // Stop bit optionally carries a one-cycle pop aligned with the word push edge
    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic pop_in_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        sig_in = stop_v;
        repeat (11) @(negedge clock);
        if (pop_in_stop) word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
        repeat (4) @(negedge clock);
        sig_in = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8], 1'b1, 1'b0);
    endtask

    task automatic pop_one();
        word_ready = 1'b1;
        @(negedge clock);
        word_ready = 1'b0;
    endtask

    initial begin
        sig_in     = 1'b1;
        word_ready = 1'b0;
        reset      = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ferr", 32'(frame_error), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_word", word_out, 32'h0);
        repeat (20) @(negedge clock);

        // Basic word
        send_byte(8'h78, 1'b1, 1'b0);
        send_byte(8'h56, 1'b1, 1'b0);
        send_byte(8'h34, 1'b1, 1'b0);
        check("t1_valid_early", 32'(word_valid), 32'd0);
        send_byte(8'h12, 1'b1, 1'b0);
        check("t1_valid", 32'(word_valid), 32'd1);
        check("t1_word", word_out, 32'h12345678);
        check("t1_count", 32'(fifo_count), 32'd1);
        check("t1_ferr", 32'(fe_cnt), 32'd0);
        pop_one();
        check("t1_count_pop", 32'(fifo_count), 32'd0);

        // Glitch on idle line
        sig_in = 1'b0;
        repeat (4) @(negedge clock);
        sig_in = 1'b1;
        repeat (40) @(negedge clock);
        check("t2_count", 32'(fifo_count), 32'd0);
        check("t2_ferr", 32'(fe_cnt), 32'd0);
        send_word(32'hDEADBEEF);
        check("t2_word", word_out, 32'hDEADBEEF);
        check("t2_count2", 32'(fifo_count), 32'd1);
        pop_one();

        // Framing error discards the partial word
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'hBB, 1'b1, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        repeat (32) @(negedge clock);
        check("t3_ferr", 32'(fe_cnt), 32'd1);
        check("t3_count_mid", 32'(fifo_count), 32'd0);
        send_word(32'h44332211);
        check("t3_count", 32'(fifo_count), 32'd1);
        check("t3_word", word_out, 32'h44332211);
        pop_one();
        check("t3_empty", 32'(word_valid), 32'd0);

        // Overflow with consumer stalled
        for (int w = 1; w <= 4; w++) send_word(32'(w));
        check("t4_count4", 32'(fifo_count), 32'd4);
        check("t4_ovf_before", 32'(overflow), 32'd0);
        send_word(32'd5);
        check("t4_count_full", 32'(fifo_count), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd1);
        for (int w = 1; w <= 4; w++) begin
            check("t4_head", word_out, 32'(w));
            repeat (3) @(negedge clock);
            check("t4_stall", word_out, 32'(w));
            pop_one();
        end
        check("t4_drained", 32'(fifo_count), 32'd0);
        check("t4_valid", 32'(word_valid), 32'd0);

        // Push and pop on the same edge
        send_word(32'hA0A0A0A0);
        send_word(32'hB1B1B1B1);
        check("t5_pre_count", 32'(fifo_count), 32'd2);
        send_byte(8'h03, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'hC0, 1'b1, 1'b1);
        check("t5_count", 32'(fifo_count), 32'd2);
        check("t5_head1", word_out, 32'hB1B1B1B1);
        pop_one();
        check("t5_head2", word_out, 32'hC0010203);
        pop_one();
        check("t5_empty", 32'(fifo_count), 32'd0);

        // Reset in the middle of the third byte
        send_word(32'hCAFEF00D);
        check("t6_pre_count", 32'(fifo_count), 32'd1);
        send_byte(8'h0D, 1'b1, 1'b0);
        send_byte(8'h0C, 1'b1, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        reset  = 1'b1;
        sig_in = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t6_valid", 32'(word_valid), 32'd0);
        check("t6_count", 32'(fifo_count), 32'd0);
        check("t6_ovf", 32'(overflow), 32'd0);
        check("t6_word", word_out, 32'h0);
        repeat (32) @(negedge clock);
        send_word(32'h0A0B0C0D);
        check("t6_new_word", word_out, 32'h0A0B0C0D);
        check("t6_new_count", 32'(fifo_count), 32'd1);
        check("total_ferr", 32'(fe_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
